// File: rtl/flit_serializer.sv
// Group-FIFO flit serializer: queues {N,S,E,W} flit groups and replays them one lane per cycle with one-hot strobes.
// Optional FLIT_SKIP_EMPTY_EN: skip lanes whose valid bit is clear (an all-empty group takes one silent cycle).
module flit_serializer #(
    parameter int DEPTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] nin,
    input  logic [10:0] sin,
    input  logic [10:0] ein,
    input  logic [10:0] win,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        out_stall,
    output logic [6:0]  out,
    output logic        nsig,
    output logic        ssig,
    output logic        esig,
    output logic        wsig
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_nxt;
    logic [3:0][6:0]   mem [DEPTH];
    logic [3:0][6:0]   din, head;
    logic [3:0]        hv;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nxt;
    logic [1:0]        lane, lane_nxt, cur;
    logic              last, push, pop;
    logic [3:0]        strb, strb_nxt;
    logic [6:0]        out_nxt;

    // Lane index 0..3 = N,S,E,W; only valid + payload bits are kept.
    assign din[0] = {nin[10], nin[5:0]};
    assign din[1] = {sin[10], sin[5:0]};
    assign din[2] = {ein[10], ein[5:0]};
    assign din[3] = {win[10], win[5:0]};

    assign head = mem[rd_ptr];
    for (genvar g = 0; g < 4; g++) begin : g_hv
        assign hv[g] = head[g][6];
    end

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        cur  = lane;
        last = (lane == 2'd3);
`ifdef FLIT_SKIP_EMPTY_EN
        // First valid lane at or after the current one; if none, stay put and emit a silent pop cycle.
        for (int i = 3; i >= 0; i--)
            if (2'(i) >= lane && hv[i]) cur = 2'(i);
        last = 1'b1;
        for (int j = 0; j < 4; j++)
            if (2'(j) > cur && hv[j]) last = 1'b0;
`endif
    end

    always_comb begin
        lane_nxt  = lane;
        pop       = 1'b0;
        strb_nxt  = '0;
        out_nxt   = out;
        count_nxt = count;
        case (state)
            SEND: if (!out_stall) begin
                out_nxt  = hv[cur] ? head[cur] : 7'd0;
                strb_nxt = hv[cur] ? (4'b0001 << cur) : 4'b0000;
                pop      = last;
                lane_nxt = last ? 2'd0 : cur + 2'd1;
            end
            default: ;
        endcase
        if (push && !pop)      count_nxt = count + CW'(1);
        else if (pop && !push) count_nxt = count - CW'(1);
        // Entering SEND on the write edge gives the one-cycle write-to-N latency.
        state_nxt = (count_nxt != '0) ? SEND : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lane   <= 2'd0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            out    <= '0;
            strb   <= '0;
        end else begin
            state <= state_nxt;
            lane  <= lane_nxt;
            count <= count_nxt;
            out   <= out_nxt;
            strb  <= strb_nxt;
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= din;
    end

    assign nsig = strb[0];
    assign ssig = strb[1];
    assign esig = strb[2];
    assign wsig = strb[3];
endmodule

// File: tb/tb_flit_serializer.sv
// Scoreboard bench for flit_serializer: strobed flits are matched in order against expectations queued at write time.
module tb_flit_serializer;
    localparam int DEPTH = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] nin = '0, sin = '0, ein = '0, win = '0;
    logic        in_valid = 1'b0, out_stall = 1'b0;
    logic        in_ready;
    logic [6:0]  out;
    logic        nsig, ssig, esig, wsig;
    logic [3:0]  strb;

    int n_chk = 0, n_fail = 0, strb_cnt = 0;
    logic [10:0] sb[$];

    flit_serializer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .nin(nin), .sin(sin), .ein(ein), .win(win),
        .in_valid(in_valid), .in_ready(in_ready), .out_stall(out_stall),
        .out(out), .nsig(nsig), .ssig(ssig), .esig(esig), .wsig(wsig)
    );

    always #5 clk = ~clk;
    assign strb = {nsig, ssig, esig, wsig};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {out, nsig,ssig,esig,wsig} of a lane when its valid bit is set.
    function automatic logic [10:0] exp_item(input logic [10:0] f, input int l);
        logic [3:0] s;
        s = 4'b1000 >> l;
        return {1'b1, f[5:0], s};
    endfunction

    task automatic write_grp(input logic [10:0] n, s, e, w, input bit acc);
        logic [10:0] f[4];
        f = '{n, s, e, w};
        nin = n; sin = s; ein = e; win = w;
        in_valid = 1'b1;
        check("in_ready_at_write", in_ready, acc);
        if (acc)
            for (int l = 0; l < 4; l++)
                if (f[l][10]) sb.push_back(exp_item(f[l], l));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && strb != 4'b0000) begin
            strb_cnt++;
            check("onehot", $countones(strb), 1);
            if (sb.size() == 0) check("sb_unexpected_flit", {out, strb}, 0);
            else check("sb_flit", {out, strb}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        cyc(2);
        check("rst_out", out, 0);
        check("rst_strb", strb, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        cyc(1);

        // Basic group, per-cycle timing.
        write_grp(11'h401, 11'h402, 11'h403, 11'h404, 1);
        cyc(1); check("t1_n", {out, strb}, {7'h41, 4'b1000});
        cyc(1); check("t1_s", {out, strb}, {7'h42, 4'b0100});
        cyc(1); check("t1_e", {out, strb}, {7'h43, 4'b0010});
        cyc(1); check("t1_w", {out, strb}, {7'h44, 4'b0001});
        cyc(1); check("t1_idle", strb, 0);
        cyc(2);

        // Overflow under stall.
        out_stall = 1'b1;
        for (int k = 0; k <= DEPTH; k++)
            write_grp(11'h400 | 11'(k * 4), 11'h400 | 11'(k * 4 + 1),
                      11'h400 | 11'(k * 4 + 2), 11'h400 | 11'(k * 4 + 3), k < DEPTH);
        check("ovf_ready_low", in_ready, 0);
        cyc(2);
        check("ovf_stall_quiet", strb, 0);
        base = strb_cnt;
        out_stall = 1'b0;
        cyc(DEPTH * 4 + 6);
        check("ovf_flit_count", strb_cnt - base, DEPTH * 4);
        check("ovf_sb_empty", sb.size(), 0);
        check("ovf_ready_back", in_ready, 1);

        // Single valid E lane.
        write_grp(11'h000, 11'h000, 11'h43F, 11'h000, 1);
`ifdef FLIT_SKIP_EMPTY_EN
        cyc(1); check("eo_e", {out, strb}, {7'h7F, 4'b0010});
        cyc(1); check("eo_idle", strb, 0);
`else
        cyc(1); check("eo_n_empty", {out, strb}, 11'h000);
        cyc(1); check("eo_s_empty", {out, strb}, 11'h000);
        cyc(1); check("eo_e", {out, strb}, {7'h7F, 4'b0010});
        cyc(1); check("eo_w_empty", {out, strb}, 11'h000);
`endif
        cyc(2);

        // Stall while S is on the lane.
        write_grp(11'h401, 11'h402, 11'h403, 11'h404, 1);
        cyc(1); check("st_n", {out, strb}, {7'h41, 4'b1000});
        cyc(1); check("st_s", {out, strb}, {7'h42, 4'b0100});
        out_stall = 1'b1;
        cyc(1); check("st_hold1", {out, strb}, {7'h42, 4'b0000});
        cyc(1); check("st_hold2", {out, strb}, {7'h42, 4'b0000});
        out_stall = 1'b0;
        cyc(1); check("st_e", {out, strb}, {7'h43, 4'b0010});
        cyc(1); check("st_w", {out, strb}, {7'h44, 4'b0001});
        cyc(1); check("st_idle", strb, 0);
        cyc(1);

        // Reset during E with 3 groups queued.
        out_stall = 1'b1;
        for (int k = 0; k < 3; k++)
            write_grp(11'h410 | 11'(k * 4), 11'h411 | 11'(k * 4),
                      11'h412 | 11'(k * 4), 11'h413 | 11'(k * 4), 1);
        out_stall = 1'b0;
        cyc(3); check("rm_e", {out, strb}, {7'h52, 4'b0010});
        rst = 1'b1;
        #1 sb.delete();
        cyc(1);
        check("rm_out", out, 0);
        check("rm_strb", strb, 0);
        check("rm_ready", in_ready, 1);
        rst = 1'b0;
        cyc(1); check("rm_post_quiet", strb, 0);
        write_grp(11'h421, 11'h422, 11'h423, 11'h424, 1);
        cyc(1); check("rm_fresh_n", {out, strb}, {7'h61, 4'b1000});
        cyc(5);

        // Full FIFO, write coincident with the W pop is rejected.
        out_stall = 1'b1;
        for (int k = 0; k < DEPTH; k++)
            write_grp(11'h430 | 11'(k), 11'h408 | 11'(k), 11'h438 | 11'(k), 11'h418 | 11'(k), 1);
        base = strb_cnt;
        out_stall = 1'b0;
        cyc(3);
        write_grp(11'h43E, 11'h43E, 11'h43E, 11'h43E, 0);
        check("full_ready_after_pop", in_ready, 1);
        cyc(DEPTH * 4 + 4);
        check("full_flit_count", strb_cnt - base, DEPTH * 4);
        check("full_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
